// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN,
    FAULT
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  localparam int unsigned PC_STEP   = 4;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - single-entry {instr, pc, fault} output buffer toward decode
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clear_i,
  input  logic            load_i,
  input  logic [31:0]     load_instr_i,
  input  logic [XLEN-1:0] load_pc_i,
  input  logic            load_fault_i,
  input  logic            ready_i,
  output logic            valid_o,
  output logic            free_o,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic            fault_o
);

  logic            valid_q, valid_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            fault_q, fault_d;

  // Payload only changes on load, so it holds while decode stalls.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      instr_d = load_instr_i;
      pc_d    = load_pc_i;
      fault_d = load_fault_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  assign valid_o = valid_q;
  assign free_o  = !valid_q || ready_i;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign fault_o = fault_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - fetch FSM issuing one imem request at a time into a decode buffer
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] pc,
  output logic            pc_enable,
  output logic [XLEN-1:0] pc_increment,
  input  logic            redirect,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            imem_rsp_error,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [31:0]     if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic            if_fault
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;

  logic            buf_free;
  logic            buf_load;
  logic [31:0]     buf_instr;
  logic [XLEN-1:0] buf_pc;
  logic            buf_fault;
  logic            pc_aligned;
  logic            req_fire;

  assign pc_aligned = (pc[1:0] == 2'b00);
  assign req_fire   = imem_req_valid && imem_req_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Redirect overrides every other transition; an accepted or outstanding request must drain.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  state_d = REQ;
      REQ: begin
        if (redirect)                      state_d = req_fire ? DRAIN : REQ;
        else if (req_fire)                 state_d = WAIT;
        else if (buf_free && !pc_aligned)  state_d = FAULT;
      end
      WAIT: begin
        if (redirect)            state_d = imem_rsp_valid ? REQ : DRAIN;
        else if (imem_rsp_valid) state_d = imem_rsp_error ? FAULT : REQ;
      end
      DRAIN: if (imem_rsp_valid) state_d = REQ;
      FAULT: if (redirect)       state_d = REQ;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    imem_req_valid = 1'b0;
    buf_load       = 1'b0;
    buf_instr      = NOP_INSTR;
    buf_pc         = pc;
    buf_fault      = 1'b0;
    case (state_q)
      REQ: begin
        imem_req_valid = buf_free && pc_aligned;
        if (!redirect && buf_free && !pc_aligned) begin
          buf_load  = 1'b1;
          buf_fault = 1'b1;
        end
      end
      WAIT: begin
        if (!redirect && imem_rsp_valid) begin
          buf_load  = 1'b1;
          buf_instr = imem_rsp_error ? NOP_INSTR : imem_rsp_data;
          buf_pc    = req_pc_q;
          buf_fault = imem_rsp_error;
        end
      end
      default: ;
    endcase
  end

  assign req_pc_d = req_fire ? pc : req_pc_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_pc_q <= '0;
    end else begin
      req_pc_q <= req_pc_d;
    end
  end

  // Gated so a redirect seen during reset cannot load the PC register.
  assign pc_enable     = req_fire || (redirect && reset_n);
  assign pc_increment  = pc + XLEN'(PC_STEP);
  assign imem_req_addr = pc;

  fetch_buffer #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_fetch_buffer (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear_i      (redirect),
    .load_i       (buf_load),
    .load_instr_i (buf_instr),
    .load_pc_i    (buf_pc),
    .load_fault_i (buf_fault),
    .ready_i      (if_ready),
    .valid_o      (if_valid),
    .free_o       (buf_free),
    .instr_o      (if_instr),
    .pc_o         (if_pc),
    .fault_o      (if_fault)
  );

endmodule
